fp_mul_issue: RTL and testbench
===============================

Name: fp_mul_issue

Overview:
- Sequential wrapper that sits around the combinational single-precision multiplier.
- Buffers incoming operand pairs in a DEPTH-entry FIFO and presents the head pair to the multiplier.
- Captures the multiplier result into a registered output stage with valid/ready handshakes on both sides.
- Classifies IEEE-754 special operands and overrides the result for NaN/Inf cases, since the multiplier returns 0 for any exponent-0xFF operand.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, width of the Count port; derived, not overridden.

Ports:
- Clk, input, 1, clock; all state updates on the rising edge.
- Rst, input, 1, synchronous active-high reset.
- InValid, input, 1, operand pair offered.
- InReady, output, 1, FIFO can accept a pair.
- InA, input, 32, operand A (IEEE-754 single).
- InB, input, 32, operand B.
- MulA, output, 32, head operand A to the multiplier; 0 when FIFO empty.
- MulB, output, 32, head operand B to the multiplier; 0 when FIFO empty.
- MulOut, input, 32, multiplier result for MulA/MulB, valid in the same cycle.
- OutValid, output, 1, result register holds a result.
- OutReady, input, 1, downstream accepts the result.
- Out, output, 32, registered product.
- OutFlags, output, 4, {NaN, Inf, Zero, Denorm} for the held result.
- Count, output, CW, FIFO occupancy (0..DEPTH); excludes the result register.

Behaviour:
- Reset:
  - Write pointer, read pointer and Count go to 0.
  - OutValid, Out and OutFlags go to 0.
  - InReady is 0 while Rst is high and 1 in the first cycle after.
  - Reset mid-operation discards all queued and held results. No partial output.
- Push: when InValid && InReady, {InA, InB} is written at the write pointer. The write pointer increments modulo DEPTH.
- InReady = !Rst && (Count != DEPTH). There is no same-cycle bypass: a full FIFO refuses a push even when a pop occurs in that cycle.
- Pop condition: Count != 0 && (!OutValid || OutReady). On a pop:
  - The read pointer increments modulo DEPTH.
  - Out and OutFlags load from the head pair.
  - OutValid is set to 1.
- When OutValid && OutReady and no pop occurs, OutValid clears to 0. Out and OutFlags keep their last value.
- While OutValid && !OutReady, Out and OutFlags stay stable.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- MulA/MulB are driven combinationally from the head entry. They are 0 when Count == 0.
- Latency: with an empty pipe, a pair accepted at edge N enters the FIFO. It pops at edge N+1, so OutValid is high after N+1. Throughput is one result per cycle while OutReady is held high.
- Ordering is strict FIFO. Capacity before InReady drops with OutReady low is DEPTH+1 pairs: DEPTH queued plus one held.
- Classification of the head pair (E = bits 30:23, F = bits 22:0):
  - isNaN: E == 8'hFF and F != 0.
  - isInf: E == 8'hFF and F == 0.
  - isZero: E == 0 and F == 0.
  - isDen: E == 0 and F != 0.
- Flag and Out rules, applied at capture:
  - NaN = either operand isNaN, or (isInf on one operand and isZero on the other). Out = 32'h7FC00000.
  - Inf = !NaN and either operand isInf. Out = {A[31]^B[31], 8'hFF, 23'd0}.
  - Zero = !NaN and !Inf and either operand isZero. Out = MulOut.
  - Denorm = either operand isDen. This flag is independent of the others. Out = MulOut unless NaN or Inf applies.
  - Otherwise Out = MulOut.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by Count, not by pointer comparison.

Test Plan:
- Reset, then push InA=0x40000000 and InB=0x40400000 with OutReady=1.
  - OutValid rises one edge after acceptance.
  - Out=0x40C00000, OutFlags=4'b0000, Count returns to 0.
- Push InA=0x7F800000 (+Inf) and InB=0x00000000.
  - Out=0x7FC00000, OutFlags=4'b1000.
- Push 0xFF800000 × 0x40000000 → Out=0xFF800000, OutFlags=4'b0100.
- Push 0x00000001 × 0x3F800000 → OutFlags[0]=1 and Out equals MulOut.
- Hold OutReady=0 (DEPTH=4) and push 6 distinct pairs.
  - Exactly 5 are accepted, then InReady=0 and Count=4.
  - Release OutReady: results drain in push order, one per cycle. The 6th pair is then accepted, exercising pointer wrap.
- Run simultaneous push and pop at Count=2 for 8 cycles → Count holds at 2 and no result is lost or duplicated.
- Assert Rst while Count=3 and OutValid=1.
  - The next cycle shows Count=0, OutValid=0, Out=0, MulA=MulB=0.
  - A fresh push then behaves as in the first scenario.

Source files
------------

// File: rtl/fp_mul_issue.sv
// Issue/capture wrapper around the combinational single-precision multiplier.
// Queues operand pairs, feeds the head pair to the multiplier and registers the result with NaN/Inf fix-up.
module fp_mul_issue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          InValid,
  output logic          InReady,
  input  logic [31:0]   InA,
  input  logic [31:0]   InB,
  output logic [31:0]   MulA,
  output logic [31:0]   MulB,
  input  logic [31:0]   MulOut,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [31:0]   Out,
  output logic [3:0]    OutFlags,
  output logic [CW-1:0] Count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   memA [DEPTH];
  logic [31:0]   memB [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          aNan, aInf, aZero, aDen;
  logic          bNan, bInf, bZero, bDen;
  logic          resNan, resInf, resZero, resDen;
  logic [31:0]   resOut;

  // Full/empty come from the occupancy counter so pointers can simply wrap.
  assign empty   = (Count == '0);
  assign full    = (Count == CW'(DEPTH));
  assign InReady = !Rst && !full;
  assign push    = InValid && InReady;
  assign pop     = !empty && (!OutValid || OutReady);

  assign MulA = empty ? 32'd0 : memA[rdPtr];
  assign MulB = empty ? 32'd0 : memB[rdPtr];

  always_comb begin
    aNan = (MulA[30:23] == 8'hFF) && (MulA[22:0] != 23'd0);
    aInf = (MulA[30:23] == 8'hFF) && (MulA[22:0] == 23'd0);
    aZero = (MulA[30:23] == 8'h00) && (MulA[22:0] == 23'd0);
    aDen = (MulA[30:23] == 8'h00) && (MulA[22:0] != 23'd0);
    bNan = (MulB[30:23] == 8'hFF) && (MulB[22:0] != 23'd0);
    bInf = (MulB[30:23] == 8'hFF) && (MulB[22:0] == 23'd0);
    bZero = (MulB[30:23] == 8'h00) && (MulB[22:0] == 23'd0);
    bDen = (MulB[30:23] == 8'h00) && (MulB[22:0] != 23'd0);
  end

  // The multiplier yields 0 for any exponent-0xFF operand, so NaN/Inf results are substituted here.
  always_comb begin
    resNan  = aNan || bNan || (aInf && bZero) || (aZero && bInf);
    resInf  = !resNan && (aInf || bInf);
    resZero = !resNan && !resInf && (aZero || bZero);
    resDen  = aDen || bDen;
    resOut  = MulOut;
    if (resNan) begin
      resOut = 32'h7FC00000;
    end else if (resInf) begin
      resOut = {MulA[31] ^ MulB[31], 8'hFF, 23'd0};
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      memA[wrPtr] <= InA;
      memB[wrPtr] <= InB;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({push, pop})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Out/OutFlags only change on a pop, so a consumed result leaves its last value visible.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      OutValid <= 1'b0;
      Out      <= '0;
      OutFlags <= '0;
    end else if (pop) begin
      OutValid <= 1'b1;
      Out      <= resOut;
      OutFlags <= {resNan, resInf, resZero, resDen};
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_mul_issue.sv
// Self-checking bench for fp_mul_issue: a stand-in multiplier drives MulOut and a queue-based
// transaction model predicts queue occupancy and captured results.
module tb_fp_mul_issue;

  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          InValid;
  logic          InReady;
  logic [31:0]   InA;
  logic [31:0]   InB;
  logic [31:0]   MulA;
  logic [31:0]   MulB;
  logic [31:0]   MulOut;
  logic          OutValid;
  logic          OutReady;
  logic [31:0]   Out;
  logic [3:0]    OutFlags;
  logic [CW-1:0] Count;

  int total = 0;
  int bad = 0;

  fp_mul_issue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .InA(InA), .InB(InB), .MulA(MulA), .MulB(MulB), .MulOut(MulOut),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out),
    .OutFlags(OutFlags), .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Stand-in multiplier: truncating normal product, 0 for exponent-0xFF operands,
  // signed zero for zero operands and a recognisable pattern for denormals.
  function automatic logic [31:0] stubMul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] m;
    logic [9:0]  e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'd0;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 8'h01, a[22:0] ^ b[22:0]};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      return {s, e[7:0], m[46:24]};
    end
    return {s, e[7:0], m[45:23]};
  endfunction

  assign MulOut = stubMul(MulA, MulB);

  // {nan, inf, zero, den} of one operand
  function automatic logic [3:0] cls(input logic [31:0] x);
    logic expMax, expMin, fracZ;
    expMax = (x[30:23] == 8'hFF);
    expMin = (x[30:23] == 8'h00);
    fracZ = (x[22:0] == 23'd0);
    return {expMax && !fracZ, expMax && fracZ, expMin && fracZ, expMin && !fracZ};
  endfunction

  // Expected {flags, out} for an operand pair
  function automatic logic [35:0] refResult(input logic [31:0] a, input logic [31:0] b);
    logic [3:0]  ca, cb;
    logic        nan, inf, zero, den;
    logic [31:0] o;
    ca = cls(a);
    cb = cls(b);
    nan = ca[3] || cb[3] || (ca[2] && cb[1]) || (ca[1] && cb[2]);
    inf = !nan && (ca[2] || cb[2]);
    zero = !nan && !inf && (ca[1] || cb[1]);
    den = ca[0] || cb[0];
    if (nan) o = 32'h7FC00000;
    else if (inf) o = {a[31] ^ b[31], 8'hFF, 23'd0};
    else o = stubMul(a, b);
    return {nan, inf, zero, den, o};
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {r[31], 8'hFF, 23'd0};
      1: return {r[31], 31'd0};
      2: return {r[31], 8'hFF, r[22:1], 1'b1};
      3: return {r[31], 8'h00, r[22:1], 1'b1};
      default: return r;
    endcase
  endfunction

  // Transaction model: pending pairs in a queue plus one held result
  logic [63:0] mq[$];
  bit          mValid = 1'b0;
  logic [31:0] mOut = 32'd0;
  logic [3:0]  mFlags = 4'd0;

  always @(posedge Clk) begin : modelBlk
    bit          doPush;
    bit          doPop;
    logic [63:0] hd;
    logic [35:0] r;
    if (Rst) begin
      mq.delete();
      mValid = 1'b0;
      mOut = 32'd0;
      mFlags = 4'd0;
    end else begin
      doPush = InValid && (mq.size() < DEPTH);
      doPop = (mq.size() > 0) && (!mValid || OutReady);
      if (doPop) begin
        hd = mq.pop_front();
        r = refResult(hd[63:32], hd[31:0]);
        mOut = r[31:0];
        mFlags = r[35:32];
        mValid = 1'b1;
      end else if (mValid && OutReady) begin
        mValid = 1'b0;
      end
      if (doPush) mq.push_back({InA, InB});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drivePair(input logic [31:0] a, input logic [31:0] b, output bit ok);
    bit ready;
    InA = a;
    InB = b;
    InValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ready = InReady;
      tick();
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    InValid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL push_timeout: pair %h x %h never accepted", a, b);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b1;
    InA = 32'd0;
    InB = 32'd0;
    tick();
    tick();
    total++;
    if (InReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_inready: got %b expected 0", InReady); end
    total++;
    if (Count !== 3'd0 || OutValid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_state: got count=%0d valid=%b expected 0/0", Count, OutValid);
    end
    total++;
    if (Out !== 32'd0 || OutFlags !== 4'd0 || MulA !== 32'd0 || MulB !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_data: got out=%h flags=%b mula=%h mulb=%h expected zeros", Out, OutFlags, MulA, MulB);
    end
    Rst = 1'b0;
    #1;
    total++;
    if (InReady !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_inready: got %b expected 1", InReady); end
  endtask

  task automatic test_basic();
    bit ok;
    drivePair(32'h40000000, 32'h40400000, ok);
    total++;
    if (Count !== 3'd1 || OutValid !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_accept: got count=%0d valid=%b expected 1/0", Count, OutValid);
    end
    tick();
    total++;
    if (OutValid !== 1'b1 || Out !== 32'h40C00000 || OutFlags !== 4'b0000) begin
      bad++; $display("[TB] FAIL basic_result: got valid=%b out=%h flags=%b expected 1/40c00000/0000", OutValid, Out, OutFlags);
    end
    total++;
    if (Count !== 3'd0) begin bad++; $display("[TB] FAIL basic_count: got %0d expected 0", Count); end
  endtask

  task automatic test_special();
    logic [31:0] ta[8] = '{32'h7F800000, 32'hFF800000, 32'h00000001, 32'h7FC00001,
                           32'h00000000, 32'h80000000, 32'h00000001, 32'h00400000};
    logic [31:0] tb[8] = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                           32'h40000000, 32'h7F800000, 32'hFF800000, 32'h00000000};
    logic [31:0] to[8] = '{32'h7FC00000, 32'hFF800000, 32'h00800001, 32'h7FC00000,
                           32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h00000000};
    logic [3:0]  tf[8] = '{4'b1000, 4'b0100, 4'b0001, 4'b1000,
                           4'b0010, 4'b1000, 4'b0101, 4'b0011};
    bit ok;
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drivePair(ta[i], tb[i], ok);
      total++;
      if (MulA !== ta[i] || MulB !== tb[i]) begin
        bad++; $display("[TB] FAIL special_head[%0d]: got %h/%h expected %h/%h", i, MulA, MulB, ta[i], tb[i]);
      end
      tick();
      total++;
      if (OutValid !== 1'b1 || Out !== to[i] || OutFlags !== tf[i]) begin
        bad++; $display("[TB] FAIL special[%0d]: got valid=%b out=%h flags=%b expected 1/%h/%b",
                        i, OutValid, Out, OutFlags, to[i], tf[i]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] pa[6];
    logic [31:0] pb[6];
    logic [31:0] got[$];
    logic [35:0] r;
    int          acc;
    bit          ready;
    bit          pend;
    for (int i = 0; i < 6; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    OutReady = 1'b0;
    acc = 0;
    for (int c = 0; c < 10 && acc < 6; c++) begin
      InA = pa[acc];
      InB = pb[acc];
      InValid = 1'b1;
      ready = InReady;
      tick();
      if (!ready) break;
      acc++;
    end
    total++;
    if (acc != 5) begin bad++; $display("[TB] FAIL bp_accepted: got %0d expected 5", acc); end
    total++;
    if (InReady !== 1'b0 || Count !== 3'd4 || OutValid !== 1'b1) begin
      bad++; $display("[TB] FAIL bp_full: got ready=%b count=%0d valid=%b expected 0/4/1", InReady, Count, OutValid);
    end
    OutReady = 1'b1;
    #1;
    total++;
    if (InReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_bypass: got %b expected 0", InReady); end
    pend = (acc == 5);
    for (int c = 0; c < 20 && got.size() < 6; c++) begin
      if (OutValid && OutReady) got.push_back(Out);
      ready = InReady;
      tick();
      if (pend && ready) begin
        pend = 1'b0;
        InValid = 1'b0;
      end
    end
    InValid = 1'b0;
    total++;
    if (got.size() != 6) begin bad++; $display("[TB] FAIL bp_drain_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      r = refResult(pa[i], pb[i]);
      total++;
      if (got[i] !== r[31:0]) begin
        bad++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", i, got[i], r[31:0]);
      end
    end
    total++;
    if (Count !== 3'd0 || OutValid !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_empty: got count=%0d valid=%b expected 0/0", Count, OutValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[11];
    logic [31:0] pb[11];
    logic [31:0] got[$];
    logic [35:0] r;
    bit          ok;
    for (int i = 0; i < 11; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) drivePair(pa[i], pb[i], ok);
    total++;
    if (Count !== 3'd2 || OutValid !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_setup: got count=%0d valid=%b expected 2/1", Count, OutValid);
    end
    OutReady = 1'b1;
    for (int i = 3; i < 11; i++) begin
      InA = pa[i];
      InB = pb[i];
      InValid = 1'b1;
      if (OutValid) got.push_back(Out);
      tick();
      total++;
      if (Count !== 3'd2) begin bad++; $display("[TB] FAIL b2b_count[%0d]: got %0d expected 2", i, Count); end
    end
    InValid = 1'b0;
    for (int c = 0; c < 20 && got.size() < 11; c++) begin
      if (OutValid && OutReady) got.push_back(Out);
      tick();
    end
    total++;
    if (got.size() != 11) begin bad++; $display("[TB] FAIL b2b_total: got %0d expected 11", got.size()); end
    for (int i = 0; i < 11 && i < got.size(); i++) begin
      r = refResult(pa[i], pb[i]);
      total++;
      if (got[i] !== r[31:0]) begin
        bad++; $display("[TB] FAIL b2b_order[%0d]: got %h expected %h", i, got[i], r[31:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] expA;
    logic [31:0] expB;
    for (int c = 0; c < 300; c++) begin
      InValid = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 2) != 0);
      InA = pickOperand();
      InB = pickOperand();
      #1;
      expA = (mq.size() > 0) ? mq[0][63:32] : 32'd0;
      expB = (mq.size() > 0) ? mq[0][31:0] : 32'd0;
      total++;
      if (InReady !== (mq.size() != DEPTH) || MulA !== expA || MulB !== expB) begin
        bad++; $display("[TB] FAIL rnd_comb[%0d]: got ready=%b mul=%h/%h expected %b/%h/%h",
                        c, InReady, MulA, MulB, mq.size() != DEPTH, expA, expB);
      end
      tick();
      total++;
      if (Count !== CW'(mq.size()) || OutValid !== mValid || Out !== mOut || OutFlags !== mFlags) begin
        bad++; $display("[TB] FAIL rnd_state[%0d]: got count=%0d valid=%b out=%h flags=%b expected %0d/%b/%h/%b",
                        c, Count, OutValid, Out, OutFlags, mq.size(), mValid, mOut, mFlags);
      end
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    total++;
    if (Count !== 3'd0 || OutValid !== 1'b0) begin
      bad++; $display("[TB] FAIL rnd_drain: got count=%0d valid=%b expected 0/0", Count, OutValid);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    OutReady = 1'b0;
    for (int i = 0; i < 4; i++) drivePair($urandom, $urandom, ok);
    total++;
    if (Count !== 3'd3 || OutValid !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_setup: got count=%0d valid=%b expected 3/1", Count, OutValid);
    end
    Rst = 1'b1;
    tick();
    total++;
    if (Count !== 3'd0 || OutValid !== 1'b0 || Out !== 32'd0 || OutFlags !== 4'd0 ||
        MulA !== 32'd0 || MulB !== 32'd0) begin
      bad++; $display("[TB] FAIL mid_reset: got count=%0d valid=%b out=%h flags=%b mul=%h/%h expected all 0",
                      Count, OutValid, Out, OutFlags, MulA, MulB);
    end
    Rst = 1'b0;
    OutReady = 1'b1;
    drivePair(32'h40000000, 32'h40400000, ok);
    tick();
    total++;
    if (OutValid !== 1'b1 || Out !== 32'h40C00000 || OutFlags !== 4'b0000 || Count !== 3'd0) begin
      bad++; $display("[TB] FAIL mid_fresh: got valid=%b out=%h flags=%b count=%0d expected 1/40c00000/0000/0",
                      OutValid, Out, OutFlags, Count);
    end
  endtask

  initial begin
    Rst = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b1;
    InA = 32'd0;
    InB = 32'd0;
    test_reset();
    test_basic();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
